// File: rtl/pc_stack_unit.sv
// Program-counter unit with a LIFO return stack for call/ret and PC-relative branching.
// One command per edge, priority ret > call > jump > branch > hold > increment.
module pc_stack_unit #(
  parameter int                ADDR_W    = 8,
  parameter int                OFF_W     = 8,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         hold,
  input  logic                         jump,
  input  logic [ADDR_W-1:0]            jumpLine,
  input  logic                         branch,
  input  logic [OFF_W-1:0]             branchOff,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         errClr,
  output logic [ADDR_W-1:0]            pcOut,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stackFull,
  output logic                         stackEmpty,
  output logic                         ovfErr,
  output logic                         unfErr
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DW-1:0]     depth_reg, depth_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;

  logic [ADDR_W-1:0] stack_mem [DEPTH];

  logic              full, empty;
  logic              push, pop;
  logic [DW-1:0]     top_cnt;
  logic [IW-1:0]     push_idx, pop_idx;
  logic [ADDR_W-1:0] pc_plus1, off_ext;

  assign full     = (depth_reg == DW'(DEPTH));
  assign empty    = (depth_reg == '0);
  assign top_cnt  = depth_reg - DW'(1);
  assign push_idx = depth_reg[IW-1:0];
  assign pop_idx  = top_cnt[IW-1:0];
  assign pc_plus1 = pc_reg + ADDR_W'(1);
  assign off_ext  = ADDR_W'($signed(branchOff));

  // A blocked call (stack full) or ret (stack empty) leaves PC and depth untouched.
  assign pop  = ret && !empty;
  assign push = !ret && call && !full;

  always_comb begin
    pc_next    = pc_reg;
    depth_next = depth_reg;
    if (ret) begin
      if (pop) begin
        pc_next    = stack_mem[pop_idx];
        depth_next = top_cnt;
      end
    end else if (call) begin
      if (push) begin
        pc_next    = jumpLine;
        depth_next = depth_reg + DW'(1);
      end
    end else if (jump) begin
      pc_next = jumpLine;
    end else if (branch) begin
      pc_next = pc_reg + off_ext;
    end else if (!hold) begin
      pc_next = pc_plus1;
    end
  end

  // Error set takes precedence over a simultaneous clear.
  assign ovf_next = (ovf_reg && !errClr) || (!ret && call && full);
  assign unf_next = (unf_reg && !errClr) || (ret && empty);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pc_reg    <= RESET_VEC;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && push_idx == IW'(i)) stack_mem[i] <= pc_plus1;
    end
  end

  assign pcOut      = pc_reg;
  assign depth      = depth_reg;
  assign stackFull  = full;
  assign stackEmpty = empty;
  assign ovfErr     = ovf_reg;
  assign unfErr     = unf_reg;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: stimulus queues hand-computed results,
// a monitor pops and checks them one edge later.
module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       rstN;
  logic       hold, jump, branch, call, ret, errClr;
  logic [7:0] jumpLine, branchOff;
  logic [7:0] pcOut;
  logic [2:0] depth;
  logic       stackFull, stackEmpty, ovfErr, unfErr;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [2:0] d;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];

  pc_stack_unit #(.ADDR_W(8), .OFF_W(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
    .clk(clk), .rstN(rstN), .hold(hold), .jump(jump), .jumpLine(jumpLine),
    .branch(branch), .branchOff(branchOff), .call(call), .ret(ret),
    .errClr(errClr), .pcOut(pcOut), .depth(depth), .stackFull(stackFull),
    .stackEmpty(stackEmpty), .ovfErr(ovfErr), .unfErr(unfErr)
  );

  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    logic xfull, xempty;
    xfull  = (e.d == 3'd4);
    xempty = (e.d == 3'd0);
    n_vec++;
    if (pcOut !== e.pc || depth !== e.d || stackFull !== xfull ||
        stackEmpty !== xempty || ovfErr !== e.ovf || unfErr !== e.unf) begin
      n_miss++;
      $display("FAIL %s: got pc=%02h d=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%02h d=%0d full=%b empty=%b ovf=%b unf=%b",
               e.name, pcOut, depth, stackFull, stackEmpty, ovfErr, unfErr,
               e.pc, e.d, xfull, xempty, e.ovf, e.unf);
    end else begin
      $display("ok   %s: pc=%02h d=%0d ovf=%b unf=%b", e.name, pcOut, depth, ovfErr, unfErr);
    end
  endtask

  // Monitor: every active edge with a pending expectation is checked 1ns later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check(exp_q.pop_front());
  end

  task automatic drive_push(input string nm, input bit h, j, b, c, r, e,
                            input logic [7:0] jl, off, pc, input logic [2:0] d,
                            input bit ovf, unf);
    exp_t x;
    hold = h; jump = j; branch = b; call = c; ret = r; errClr = e;
    jumpLine = jl; branchOff = off;
    x.name = nm; x.pc = pc; x.d = d; x.ovf = ovf; x.unf = unf;
    exp_q.push_back(x);
  endtask

  task automatic step(input string nm, input bit h, j, b, c, r, e,
                      input logic [7:0] jl, off, pc, input logic [2:0] d,
                      input bit ovf, unf);
    @(negedge clk);
    drive_push(nm, h, j, b, c, r, e, jl, off, pc, d, ovf, unf);
  endtask

  task automatic clear_inputs();
    hold = 0; jump = 0; branch = 0; call = 0; ret = 0; errClr = 0;
    jumpLine = 8'h00; branchOff = 8'h00;
  endtask

  initial begin
    exp_t r;
    clear_inputs();
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    r.name = "reset"; r.pc = 8'h00; r.d = 0; r.ovf = 0; r.unf = 0;
    check(r);
    @(negedge clk);
    rstN = 1'b1;
    //           name          h j b c r e  jl     off    pc     d  ovf unf
    drive_push("idle1",       0,0,0,0,0,0, 8'h00, 8'h00, 8'h01, 0, 0, 0);
    step("idle2",             0,0,0,0,0,0, 8'h00, 8'h00, 8'h02, 0, 0, 0);
    step("idle3",             0,0,0,0,0,0, 8'h00, 8'h00, 8'h03, 0, 0, 0);
    step("jmp_fe",            0,1,0,0,0,0, 8'hFE, 8'h00, 8'hFE, 0, 0, 0);
    step("inc_ff",            0,0,0,0,0,0, 8'h00, 8'h00, 8'hFF, 0, 0, 0);
    step("inc_wrap",          0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    step("jmp_10",            0,1,0,0,0,0, 8'h10, 8'h00, 8'h10, 0, 0, 0);
    step("br_neg16",          0,0,1,0,0,0, 8'h00, 8'hF0, 8'h00, 0, 0, 0);
    step("jmp_f8",            0,1,0,0,0,0, 8'hF8, 8'h00, 8'hF8, 0, 0, 0);
    step("br_wrap_up",        0,0,1,0,0,0, 8'h00, 8'h10, 8'h08, 0, 0, 0);
    step("jmp_05",            0,1,0,0,0,0, 8'h05, 8'h00, 8'h05, 0, 0, 0);
    step("call_40",           0,0,0,1,0,0, 8'h40, 8'h00, 8'h40, 1, 0, 0);
    step("call_80",           0,0,0,1,0,0, 8'h80, 8'h00, 8'h80, 2, 0, 0);
    step("ret_41",            0,0,0,0,1,0, 8'h00, 8'h00, 8'h41, 1, 0, 0);
    step("ret_06",            0,0,0,0,1,0, 8'h00, 8'h00, 8'h06, 0, 0, 0);
    step("fill_call1",        0,0,0,1,0,0, 8'h10, 8'h00, 8'h10, 1, 0, 0);
    step("fill_call2",        0,0,0,1,0,0, 8'h20, 8'h00, 8'h20, 2, 0, 0);
    step("fill_call3",        0,0,0,1,0,0, 8'h30, 8'h00, 8'h30, 3, 0, 0);
    step("fill_call4",        0,0,0,1,0,0, 8'h40, 8'h00, 8'h40, 4, 0, 0);
    step("call_full",         0,0,0,1,0,0, 8'h99, 8'h00, 8'h40, 4, 1, 0);
    step("ret_after_ovf",     0,0,0,0,1,0, 8'h00, 8'h00, 8'h31, 3, 1, 0);
    step("errclr_ovf",        0,0,0,0,0,1, 8'h00, 8'h00, 8'h32, 3, 0, 0);
    step("hold_jump",         1,1,0,0,0,0, 8'h33, 8'h00, 8'h33, 3, 0, 0);
    step("hold1",             1,0,0,0,0,0, 8'h00, 8'h00, 8'h33, 3, 0, 0);
    step("hold2",             1,0,0,0,0,0, 8'h00, 8'h00, 8'h33, 3, 0, 0);
    step("hold3",             1,0,0,0,0,0, 8'h00, 8'h00, 8'h33, 3, 0, 0);
    step("ret_21",            0,0,0,0,1,0, 8'h00, 8'h00, 8'h21, 2, 0, 0);
    step("ret_11",            0,0,0,0,1,0, 8'h00, 8'h00, 8'h11, 1, 0, 0);
    step("ret_call_pop",      0,0,0,1,1,0, 8'h55, 8'h00, 8'h07, 0, 0, 0);
    step("ret_empty",         0,0,0,0,1,0, 8'h00, 8'h00, 8'h07, 0, 0, 1);
    step("unf_set_wins",      0,0,0,0,1,1, 8'h00, 8'h00, 8'h07, 0, 0, 1);
    step("errclr_unf",        0,0,0,0,0,1, 8'h00, 8'h00, 8'h08, 0, 0, 0);
    step("hold_branch",       1,0,1,0,0,0, 8'h00, 8'h02, 8'h0A, 0, 0, 0);
    step("jump_over_branch",  0,1,1,0,0,0, 8'h50, 8'h05, 8'h50, 0, 0, 0);
    step("pre_call1",         0,0,0,1,0,0, 8'h60, 8'h00, 8'h60, 1, 0, 0);
    step("pre_call2",         0,0,0,1,0,0, 8'h61, 8'h00, 8'h61, 2, 0, 0);
    step("pre_call3",         0,0,0,1,0,0, 8'h62, 8'h00, 8'h62, 3, 0, 0);
    step("pre_call4",         0,0,0,1,0,0, 8'h63, 8'h00, 8'h63, 4, 0, 0);
    step("pre_ovf",           0,0,0,1,0,0, 8'h64, 8'h00, 8'h63, 4, 1, 0);
    step("pre_ret",           0,0,0,0,1,0, 8'h00, 8'h00, 8'h63, 3, 1, 0);
    step("pre_jmp_77",        0,1,0,0,0,0, 8'h77, 8'h00, 8'h77, 3, 1, 0);

    // Assert reset between edges and check before the next edge arrives.
    @(posedge clk);
    #3;
    clear_inputs();
    rstN = 1'b0;
    #1;
    r.name = "async_reset"; r.pc = 8'h00; r.d = 0; r.ovf = 0; r.unf = 0;
    check(r);
    @(negedge clk);
    rstN = 1'b1;
    drive_push("post_reset_inc", 0,0,0,0,0,0, 8'h00, 8'h00, 8'h01, 0, 0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit with an internal call/return stack and PC-relative branching. It generalises the plain 8-bit increment/jump/hold counter. It sits at the front of the fetch path and drives the instruction-memory address every cycle. It owns the PC register itself rather than taking the current value back as an input.

## Interface
Parameters:
- ADDR_W, default 8: PC and return-address width.
- OFF_W, default 8: width of the signed branch offset; must satisfy OFF_W <= ADDR_W.
- DEPTH, default 4: return-stack entries; must be >= 1.
- RESET_VEC, default 0: PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous, active-low reset.
- hold  in  1  stall; freezes sequential increment only.
- jump  in  1  absolute jump to jumpLine.
- jumpLine  in  ADDR_W  absolute target for jump and call.
- branch  in  1  relative branch.
- branchOff  in  OFF_W  signed two's-complement offset, added to the current PC.
- call  in  1  push PC+1 and jump to jumpLine.
- ret  in  1  pop the stack top into the PC.
- errClr  in  1  clears the sticky error flags.
- pcOut  out  ADDR_W  current PC, registered.
- depth  out  clog2(DEPTH+1)  number of valid stack entries.
- stackFull  out  1  high when depth == DEPTH (combinational from depth).
- stackEmpty  out  1  high when depth == 0.
- ovfErr  out  1  sticky: a call was attempted while the stack was full.
- unfErr  out  1  sticky: a ret was attempted while the stack was empty.

## Operation
- Reset (rstN low, asynchronous, no clock needed):
  - pcOut = RESET_VEC, depth = 0, ovfErr = 0, unfErr = 0.
  - Stack contents are don't-care.
- Each rising edge acts on exactly one command, in this priority order: ret > call > jump > branch > hold > increment. Lower-priority requests in the same cycle are ignored.
- ret, stack non-empty: pcOut <= stack[depth-1]; depth decrements.
- ret, stack empty: pcOut unchanged; unfErr <= 1; depth stays 0.
- call, stack not full: stack[depth] <= pcOut+1 (mod 2^ADDR_W); pcOut <= jumpLine; depth increments.
- call, stack full: no push; pcOut unchanged; ovfErr <= 1. The call is blocked entirely and no jump happens.
- jump: pcOut <= jumpLine.
- branch: pcOut <= pcOut + sign_extend(branchOff), modulo 2^ADDR_W. Wrap-around in either direction is legal and silent.
- hold, with no transfer command active: pcOut unchanged. Control transfers override hold.
- No command active: pcOut <= pcOut + 1, wrapping from 2^ADDR_W-1 to 0.
- The stack is a LIFO indexed by depth; no entry is ever overwritten while it is valid.
- Error flags:
  - Once set, ovfErr and unfErr stay set until errClr is sampled high or reset occurs.
  - errClr clears both flags on that edge.
  - If an error event coincides with errClr, the flag ends set: the set wins.
- Unknown (X) inputs are not a supported mode; the bench drives all controls to known levels after reset.

## Timing
- Every command has single-cycle latency: its effect is visible on pcOut, depth and the flags immediately after the rising edge where it is sampled.
- The stack read for ret uses the pre-edge depth.
- call followed by ret on the next cycle returns to the call-site PC+1, so a call at PC=p yields p+1 two edges later.
- call issued when depth == DEPTH-1 succeeds; stackFull rises after that edge.
- Asserting rstN low mid-sequence takes effect immediately, asynchronously, on pcOut, depth and the flags.
- Deasserting rstN is expected synchronous to clk; the first increment happens on the first edge with rstN high.
- There is no combinational path from inputs to pcOut.

## Test plan
All cases use ADDR_W=8, OFF_W=8, DEPTH=4, RESET_VEC=0x00 unless stated.

- Reset then 3 idle edges -> pcOut 0x00, 0x01, 0x02, 0x03; depth 0; stackEmpty 1.
- pcOut=0xFE, idle for 2 edges -> 0xFF then 0x00. pcOut=0x10 with branchOff=0xF0 (-16) -> 0x00. pcOut=0xF8 with branchOff=0x10 -> 0x08.
- Nested calls:
  - At PC 0x05, call to 0x40 -> pcOut 0x40, depth 1.
  - At 0x40, call to 0x80 -> pcOut 0x80, depth 2.
  - ret -> 0x41; ret -> 0x06; depth 0.
- Four calls fill the stack (stackFull=1). A fifth call to 0x99 -> pcOut unchanged, ovfErr=1, depth 4. Next, ret -> the fourth return address. errClr -> ovfErr=0.
- Priority:
  - hold=1 with jump=1, jumpLine=0x33 -> pcOut 0x33.
  - hold alone -> pcOut frozen for 3 edges.
  - ret+call together with depth 1 -> pop only; call ignored.
  - ret with depth 0 -> pcOut unchanged, unfErr=1.
- Reset mid-operation: with depth 3, ovfErr=1, pcOut=0x77, pull rstN low between edges -> pcOut 0x00, depth 0, ovfErr 0 immediately, before any clock edge.
